counter_mod_v4: RTL and testbench
=================================

Name: counter_mod_v4

Overview:
Parametrised successor to the team's plain up/down counter. Adds a programmable upper limit (modulus), a programmable step size, and three overflow modes: wrap, saturate and one-shot. It also produces a registered terminal-count pulse and a busy flag. Used as a timer/tick generator and as a general loadable counter in datapath control.

Parameters:
W, 16, counter and limit width (>= 2)
STEP_W, 4, width of step input (STEP_W <= W)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ce  input  1  count enable
load  input  1  load cnt from load_val (independent of ce)
load_val  input  W  value to load
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount (zero-extended to W)
limit  input  W  upper bound of count range [0, limit]
mode  input  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (treated as WRAP)
start  input  1  arm one-shot run (ONESHOT mode only)
cnt  output  W  current count (registered)
tc  output  1  terminal-count pulse (registered, 1 cycle)
busy  output  1  high while one-shot is in RUN

Behaviour:
- Reset (rst_n = 0 at posedge clk): cnt = 0, tc = 0, busy = 0, FSM = IDLE. Reset has highest priority.
- Priority per cycle: rst_n > load > start > ce count.
- load: cnt <= load_val, tc <= 0. FSM state is unchanged. load_val > limit is accepted as-is.
- Arithmetic: sum = {1'b0, cnt} + step, computed in W+1 bits. Up-overflow when sum > limit. Down-underflow when step > cnt.
- step = 0: cnt holds and tc stays 0, even with ce = 1.
- Only one count update per cycle. All outputs are registered, so cnt/tc are visible the cycle after the enabling edge.
- WRAP, ce = 1:
  - up: overflow -> cnt <= 0, tc <= 1; else cnt <= sum.
  - down: underflow -> cnt <= limit, tc <= 1; else cnt <= cnt - step.
  - The overshoot remainder is discarded; the counter always restarts exactly at 0 or limit.
- SAT, ce = 1:
  - up: overflow or result == limit -> cnt <= limit.
  - down: underflow or result == 0 -> cnt <= 0.
  - tc <= 1 only on the transition onto the boundary value. While already at the boundary, cnt holds and tc stays 0.
- ONESHOT, FSM states IDLE / RUN / DONE:
  - IDLE or DONE, start = 1 -> RUN; cnt <= (up_down ? 0 : limit); tc <= 0.
  - RUN, ce = 1: counts with SAT arithmetic. On reaching the boundary (limit if up, 0 if down) -> DONE, tc <= 1 for one cycle.
  - start while in RUN is ignored.
  - In IDLE or DONE, ce has no effect on cnt.
  - busy = (state == RUN), registered.
- Mode change takes effect from the next cycle. If mode leaves ONESHOT while in RUN, FSM -> IDLE and busy -> 0; cnt is kept.
- tc defaults to 0 every cycle unless set by the rules above.
- up_down, step and limit are sampled every cycle and may change between counts.
- limit = 0: WRAP up with step >= 1 gives cnt = 0 with tc on every ce cycle.

Decomposition:
- Package counter_v4_pkg:
  - mode_e enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD)
  - os_state_e enum (OS_IDLE, OS_RUN, OS_DONE)
- Sub-module counter_v4_next (purely combinational):
  - inputs: cnt, step, limit, up_down, sat
  - outputs: next value, hit_boundary
  - the top level owns the registers and the FSM.

Test Plan:
- Reset: drive rst_n = 0 with ce = 1, load = 1 -> cnt = 0, tc = 0, busy = 0; rst_n = 1 -> counting resumes from 0.
- WRAP up: limit = 9, step = 1, ce = 1 from 0 -> cnt 1..9, then 0 with tc high exactly in the cycle cnt = 0. With step = 4 from 8 -> cnt 0, tc = 1.
- SAT down: load 5, step = 2, limit = 100, up_down = 0 -> cnt 3, 1, 0 (tc = 1 only on the 0 cycle); further ce keeps cnt 0, tc 0.
- ONESHOT: limit = 3, up, pulse start -> busy = 1, cnt 0, 1, 2, 3; tc = 1 and busy = 0 on the cnt = 3 cycle. Further ce leaves cnt at 3. A second start restarts at 0.
- Priority: load = 1, load_val = 0x1234, ce = 1, start = 1 in the same cycle (ONESHOT IDLE) -> cnt = 0x1234, FSM stays IDLE. Load with ce = 0 -> still loads.
- Boundaries: step = 0 -> cnt holds, tc = 0. W = 16, limit = 0xFFFF, cnt = 0xFFFE, step = 3, WRAP up -> cnt 0, tc 1 (no W-bit truncation error). Mode change ONESHOT -> WRAP mid-RUN -> busy falls next cycle.

Source files
------------

// File: rtl/counter_v4_pkg.sv
// Shared types for the counter_mod_v4 family: overflow-mode and one-shot FSM
// encodings, plus the mode decoder used by the top level.
package counter_v4_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_e;

  // The reserved encoding behaves exactly like WRAP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    m = mode_e'(raw);
    return (m == MODE_RSVD) ? MODE_WRAP : m;
  endfunction

endpackage

// File: rtl/counter_v4_next.sv
// Combinational next-count calculator: one up/down step with either wrap or
// saturate handling at the [0, limit] range boundaries.
module counter_v4_next
  import counter_v4_pkg::*;
#(
  parameter int W      = 16,
  parameter int STEP_W = 4
) (
  input  logic [W-1:0]      cnt,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      limit,
  input  logic              up_down,
  input  logic              sat,
  output logic [W-1:0]      nxt,
  output logic              hit_boundary
);

  logic [W-1:0] step_ext;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic         ovf;
  logic         unf;

  assign step_ext = W'(step);
  // One extra bit keeps the carry so cnt + step past 2**W-1 still compares
  // correctly against limit.
  assign sum      = {1'b0, cnt} + {1'b0, step_ext};
  assign diff     = cnt - step_ext;
  assign ovf      = sum > {1'b0, limit};
  assign unf      = step_ext > cnt;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    nxt          = cnt;
    hit_boundary = 1'b0;
    if (step_ext == '0) begin
      nxt = cnt;
    end else if (up_down) begin
      if (sat) begin
        if (ovf || (sum == {1'b0, limit})) begin
          nxt          = limit;
          hit_boundary = (cnt != limit);
        end else begin
          nxt = sum[W-1:0];
        end
      end else if (ovf) begin
        nxt          = '0;
        hit_boundary = 1'b1;
      end else begin
        nxt = sum[W-1:0];
      end
    end else begin
      if (sat) begin
        if (unf || (diff == '0)) begin
          nxt          = '0;
          hit_boundary = (cnt != '0);
        end else begin
          nxt = diff;
        end
      end else if (unf) begin
        nxt          = limit;
        hit_boundary = 1'b1;
      end else begin
        nxt = diff;
      end
    end
  end

endmodule

// File: rtl/counter_mod_v4.sv
// Loadable up/down counter with programmable limit and step, wrap/saturate/
// one-shot overflow modes, registered terminal-count pulse and busy flag.
module counter_mod_v4
  import counter_v4_pkg::*;
#(
  parameter int W      = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      limit,
  input  logic [1:0]        mode,
  input  logic              start,
  output logic [W-1:0]      cnt,
  output logic              tc,
  output logic              busy
);

  if (W < 2 || STEP_W > W || STEP_W < 1) begin : g_param_check
    $error("counter_mod_v4: need W >= 2 and 1 <= STEP_W <= W");
  end

  mode_e        md;
  os_state_e    state;
  os_state_e    state_nxt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] calc_nxt;
  logic [W-1:0] target;
  logic         tc_nxt;
  logic         busy_nxt;
  logic         hit;
  logic         sat_mode;
  logic         run_done;

  assign md       = decode_mode(mode);
  assign sat_mode = (md == MODE_SAT) || (md == MODE_ONESHOT);

  counter_v4_next #(
    .W      (W),
    .STEP_W (STEP_W)
  ) u_next (
    .cnt          (cnt),
    .step         (step),
    .limit        (limit),
    .up_down      (up_down),
    .sat          (sat_mode),
    .nxt          (calc_nxt),
    .hit_boundary (hit)
  );

  // A one-shot run ends when the saturating step lands on its end point,
  // including a run armed with limit = 0 that starts there.
  assign target   = up_down ? limit : '0;
  assign run_done = (step != '0) && (calc_nxt == target);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tc_nxt    = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (md == MODE_ONESHOT) begin
      if (state != OS_RUN && start) begin
        state_nxt = OS_RUN;
        cnt_nxt   = up_down ? '0 : limit;
      end else if (state == OS_RUN && ce) begin
        cnt_nxt = calc_nxt;
        if (run_done) begin
          state_nxt = OS_DONE;
          tc_nxt    = 1'b1;
        end
      end
    end else begin
      // Leaving one-shot mode abandons any run; the count itself is kept.
      state_nxt = OS_IDLE;
      if (ce) begin
        cnt_nxt = calc_nxt;
        tc_nxt  = hit;
      end
    end
    busy_nxt = (state_nxt == OS_RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= OS_IDLE;
      cnt   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tc    <= tc_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod_v4.sv
// Directed bench for counter_mod_v4: a table of stateful vectors followed by
// hand-written one-shot sequences; every expected value is hand-computed.
module tb_counter_mod_v4;

  localparam int W      = 16;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ce;
  logic              load;
  logic [W-1:0]      load_val;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [W-1:0]      limit;
  logic [1:0]        mode;
  logic              start;
  logic [W-1:0]      cnt;
  logic              tc;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  counter_mod_v4 #(.W(W), .STEP_W(STEP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .load     (load),
    .load_val (load_val),
    .up_down  (up_down),
    .step     (step),
    .limit    (limit),
    .mode     (mode),
    .start    (start),
    .cnt      (cnt),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst_n;
    logic              ce;
    logic              load;
    logic [W-1:0]      load_val;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [W-1:0]      limit;
    logic [1:0]        mode;
    logic              start;
    logic [W-1:0]      exp_cnt;
    logic              exp_tc;
    logic              exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic c, input logic l,
                              input logic [W-1:0] lv, input logic ud,
                              input logic [STEP_W-1:0] st, input logic [W-1:0] lim,
                              input logic [1:0] md, input logic s,
                              input logic [W-1:0] ec, input logic et, input logic eb);
    vec_t v;
    v.rst_n = r;   v.ce = c;      v.load = l;    v.load_val = lv;
    v.up_down = ud; v.step = st;  v.limit = lim; v.mode = md;
    v.start = s;   v.exp_cnt = ec; v.exp_tc = et; v.exp_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector away from the edge, clock it, then sample 1 ns later.
  task automatic apply(input vec_t v, input string tag);
    rst_n    = v.rst_n;
    ce       = v.ce;
    load     = v.load;
    load_val = v.load_val;
    up_down  = v.up_down;
    step     = v.step;
    limit    = v.limit;
    mode     = v.mode;
    start    = v.start;
    @(posedge clk);
    #1;
    check({tag, " cnt"},  32'(cnt),  32'(v.exp_cnt));
    check({tag, " tc"},   32'(tc),   32'(v.exp_tc));
    check({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; load = 1'b0; load_val = '0; up_down = 1'b1;
    step = '0; limit = '0; mode = 2'd0; start = 1'b0;

    //            r  ce ld lv       ud st lim      md s   cnt      tc eb
    // reset dominates load and ce
    vecs.push_back(mk(0, 1, 1, 16'h0055, 1, 1, 16'd9,   0, 0, 16'd0,   0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0055, 1, 1, 16'd9,   0, 0, 16'd0,   0, 0));
    // WRAP up 1..9, then 0 with tc, then 1
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk(1, 1, 0, 16'h0, 1, 1, 16'd9, 0, 0, 16'(k), 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'd9,   0, 0, 16'd0,   1, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'd9,   0, 0, 16'd1,   0, 0));
    // WRAP up step 4 from 8: overshoot discarded
    vecs.push_back(mk(1, 0, 1, 16'd8,    1, 4, 16'd9,   0, 0, 16'd8,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 4, 16'd9,   0, 0, 16'd0,   1, 0));
    // reserved mode behaves as WRAP
    vecs.push_back(mk(1, 0, 1, 16'd7,    1, 1, 16'd9,   3, 0, 16'd7,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd9,   3, 0, 16'd8,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd9,   3, 0, 16'd9,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd9,   3, 0, 16'd0,   1, 0));
    // SAT down from 5 step 2: 3, 1, 0(tc), then held
    vecs.push_back(mk(1, 0, 1, 16'd5,    0, 2, 16'd100, 1, 0, 16'd5,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 2, 16'd100, 1, 0, 16'd3,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 2, 16'd100, 1, 0, 16'd1,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 2, 16'd100, 1, 0, 16'd0,   1, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 2, 16'd100, 1, 0, 16'd0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 2, 16'd100, 1, 0, 16'd0,   0, 0));
    // SAT up from 7 step 2, limit 10: 9, 10(tc), held
    vecs.push_back(mk(1, 0, 1, 16'd7,    1, 2, 16'd10,  1, 0, 16'd7,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 2, 16'd10,  1, 0, 16'd9,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 2, 16'd10,  1, 0, 16'd10,  1, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 2, 16'd10,  1, 0, 16'd10,  0, 0));
    // step 0 holds, no tc
    vecs.push_back(mk(1, 0, 1, 16'd5,    1, 0, 16'd9,   0, 0, 16'd5,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 0, 16'd9,   0, 0, 16'd5,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 0, 16'd9,   0, 0, 16'd5,   0, 0));
    // full-width wrap: 0xFFFE + 3 exceeds 0xFFFF
    vecs.push_back(mk(1, 0, 1, 16'hFFFE, 1, 3, 16'hFFFF, 0, 0, 16'hFFFE, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 3, 16'hFFFF, 0, 0, 16'd0,   1, 0));
    // WRAP down underflow restarts at limit
    vecs.push_back(mk(1, 0, 1, 16'd1,    0, 3, 16'd20,  0, 0, 16'd1,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 3, 16'd20,  0, 0, 16'd20,  1, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    0, 3, 16'd20,  0, 0, 16'd17,  0, 0));
    // limit 0: tc on every ce cycle
    vecs.push_back(mk(1, 0, 1, 16'd0,    1, 1, 16'd0,   0, 0, 16'd0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd0,   0, 0, 16'd0,   1, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd0,   0, 0, 16'd0,   1, 0));
    // priority: load beats start and ce; FSM stays IDLE
    vecs.push_back(mk(1, 1, 1, 16'h1234, 1, 1, 16'd9,   2, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0042, 1, 1, 16'd9,   2, 0, 16'h0042, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd9,   2, 0, 16'h0042, 0, 0));
    // mid-run reset, counting resumes from 0
    vecs.push_back(mk(0, 1, 1, 16'h0099, 1, 1, 16'd9,   0, 1, 16'd0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 16'd0,    1, 1, 16'd9,   0, 0, 16'd1,   0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // one-shot up to limit 3, then restart
    apply(mk(1, 0, 0, 16'd0, 1, 1, 16'd3, 2, 1, 16'd0, 0, 1), "os_arm");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd1, 0, 1), "os_c1");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd2, 0, 1), "os_c2");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd3, 1, 0), "os_done");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd3, 0, 0), "os_hold1");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd3, 0, 0), "os_hold2");
    apply(mk(1, 0, 0, 16'd0, 1, 1, 16'd3, 2, 1, 16'd0, 0, 1), "os_rearm");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd1, 0, 1), "os_r1");
    // start during RUN is ignored; counting continues
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 1, 16'd2, 0, 1), "os_start_in_run");
    // leaving one-shot mid-run drops busy and keeps cnt
    apply(mk(1, 0, 0, 16'd0, 1, 1, 16'd3, 0, 0, 16'd2, 0, 0), "os_mode_exit");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd2, 0, 0), "os_idle_ce");
    // down-counting run from limit 2
    apply(mk(1, 0, 0, 16'd0, 0, 1, 16'd2, 2, 1, 16'd2, 0, 1), "os_dn_arm");
    apply(mk(1, 1, 0, 16'd0, 0, 1, 16'd2, 2, 0, 16'd1, 0, 1), "os_dn1");
    apply(mk(1, 1, 0, 16'd0, 0, 1, 16'd2, 2, 0, 16'd0, 1, 0), "os_dn_done");
    // load during RUN changes cnt but not the FSM
    apply(mk(1, 0, 0, 16'd0, 1, 1, 16'd3, 2, 1, 16'd0, 0, 1), "os_ld_arm");
    apply(mk(1, 1, 1, 16'd1, 1, 1, 16'd3, 2, 0, 16'd1, 0, 1), "os_ld");
    apply(mk(1, 1, 0, 16'd0, 1, 1, 16'd3, 2, 0, 16'd2, 0, 1), "os_ld_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
